// File: rtl/serial_adder_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : serial_adder_pkg
//  Purpose  : Shared types and constants for the bit-serial adder block:
//             FSM state enumeration, state encodings and default width.
//  Revision : 1.0  initial release
// ============================================================================
package serial_adder_pkg;

  // Default operand/result width (must be at least 2)
  localparam int DEFAULT_WIDTH = 8;

  // Named FSM states, convenient for debug views and waveform decoding
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_e;

  // Explicit-width state encodings used by the RTL state register
  localparam logic [1:0] c_IDLE  = IDLE;
  localparam logic [1:0] c_SHIFT = SHIFT;
  localparam logic [1:0] c_DONE  = DONE;

endpackage : serial_adder_pkg
`default_nettype wire

// File: rtl/serial_adder_if.sv
`default_nettype none
// ============================================================================
//  Module   : serial_adder_if
//  Purpose  : Operand/result handshake bundle for the bit-serial adder.
//             master = producer/consumer side, slave = adder side.
//  Revision : 1.0  initial release
// ============================================================================
interface serial_adder_if
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  // Operand side
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;

  // Result side
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;

  // Status
  logic             busy;

  modport master (
    output in_valid,
    input  in_ready,
    output a,
    output b,
    output cin,
    input  out_valid,
    output out_ready,
    input  sum,
    input  cout,
    input  busy
  );

  modport slave (
    input  in_valid,
    output in_ready,
    input  a,
    input  b,
    input  cin,
    output out_valid,
    input  out_ready,
    output sum,
    output cout,
    output busy
  );

endinterface : serial_adder_if
`default_nettype wire

// File: rtl/fulladder.sv
`default_nettype none
// ============================================================================
//  Module   : fulladder
//  Purpose  : One-bit full adder cell: s1 = a1^b1^c1, c2 = majority(a1,b1,c1).
//  Revision : 1.0  initial release
// ============================================================================
module fulladder (
  input  wire logic a1,
  input  wire logic b1,
  input  wire logic c1,
  output logic      s1,
  output logic      c2
);

  // Sum bit and carry-out of a single bit position
  always_comb begin
    s1 = a1 ^ b1 ^ c1;
    c2 = (a1 & b1) | (a1 & c1) | (b1 & c1);
  end

endmodule : fulladder
`default_nettype wire

// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
//  Module   : serial_adder
//  Purpose  : Bit-serial unsigned adder. Accepts A, B and carry-in, then forms
//             one sum bit per cycle LSB-first over WIDTH cycles and presents
//             {cout, sum} with a valid/ready handshake.
//  Revision : 1.0  initial release
// ============================================================================
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  wire logic        clk,
  input  wire logic        rst,
  serial_adder_if.slave    bus
);

  // Counter only has to reach WIDTH-1, so clog2(WIDTH) bits suffice
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(WIDTH - 1);

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic             r_carry;
  logic [CNT_W-1:0] r_cnt;

  logic             w_accept;
  logic             w_last;
  logic             w_sum_bit;
  logic             w_carry_nxt;

  // Acceptance only in IDLE; reset priority is handled inside the flops
  assign w_accept = (r_state == c_IDLE) && bus.in_valid;
  assign w_last   = (r_cnt == c_CNT_LAST);

  // Single full-adder cell working on the current LSBs and the carry flop
  fulladder u_fa (
    .a1 (r_a[0]),
    .b1 (r_b[0]),
    .c1 (r_carry),
    .s1 (w_sum_bit),
    .c2 (w_carry_nxt)
  );

  // State sequencing and bit counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (w_accept) begin
            r_cnt   <= '0;
            r_state <= c_SHIFT;
          end
        end
        c_SHIFT: begin
          // Exit on the last bit instead of incrementing, so the counter never wraps
          if (w_last) begin
            r_state <= c_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        c_DONE: begin
          if (bus.out_ready) begin
            r_state <= c_IDLE;
          end
        end
        default: begin
          r_state <= c_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // Operand shift registers, result shift register and carry flop
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_carry <= 1'b0;
    end else begin
      if (w_accept) begin
        // Result register is left alone so the previous sum stays visible in IDLE
        r_a     <= bus.a;
        r_b     <= bus.b;
        r_carry <= bus.cin;
      end else if (r_state == c_SHIFT) begin
        r_a     <= r_a >> 1;
        r_b     <= r_b >> 1;
        r_res   <= {w_sum_bit, r_res[WIDTH-1:1]};
        r_carry <= w_carry_nxt;
      end
    end
  end

  // Handshake and result outputs; in_ready is masked by reset directly
  assign bus.in_ready  = (r_state == c_IDLE) && !rst;
  assign bus.out_valid = (r_state == c_DONE);
  assign bus.busy      = (r_state != c_IDLE);
  assign bus.sum       = r_res;
  assign bus.cout      = r_carry;

endmodule : serial_adder
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_adder
//  Purpose  : Self-checking bench for serial_adder (WIDTH=8): directed cases,
//             backpressure, reset abort and randomized operations against an
//             arithmetic reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_serial_adder;

  localparam int WIDTH = 8;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  serial_adder_if #(.WIDTH(WIDTH)) bus ();

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for the whole bench
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: plain unsigned addition, {cout,sum}
  function automatic logic [WIDTH:0] ref_add(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b,
                                             input logic cin);
    return {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
  endfunction

  // Present an operand set at a falling edge; returns after the accepting edge
  task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic cin);
    @(negedge clk);
    check("issue_in_ready", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.a        = a;
    bus.b        = b;
    bus.cin      = cin;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  // Called one half-cycle after the accepting edge; checks latency, hold, consume
  task automatic wait_result(input string tag, input logic [WIDTH:0] exp, input int hold);
    for (int n = 1; n < WIDTH; n++) begin
      @(negedge clk);
      check({tag, "_early_valid"}, 32'(bus.out_valid), 32'd0);
      check({tag, "_shift_ready"}, 32'(bus.in_ready), 32'd0);
    end
    @(negedge clk);
    check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    check({tag, "_result"}, 32'({bus.cout, bus.sum}), 32'(exp));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check({tag, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
      check({tag, "_hold_result"}, 32'({bus.cout, bus.sum}), 32'(exp));
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check({tag, "_consumed_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_idle_ready"}, 32'(bus.in_ready), 32'd1);
    check({tag, "_idle_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_retained"}, 32'({bus.cout, bus.sum}), 32'(exp));
  endtask

  // Main stimulus sequence
  initial begin
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic             rc;
    bit               seen_valid;

    n_checks      = 0;
    n_errors      = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    bus.out_ready = 1'b0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_result", 32'({bus.cout, bus.sum}), 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Directed arithmetic cases
    issue(8'h03, 8'h05, 1'b0);
    wait_result("add_3_5", 9'h008, 0);
    issue(8'hFF, 8'h01, 1'b0);
    wait_result("add_ff_01", 9'h100, 1);
    issue(8'hFF, 8'hFF, 1'b1);
    wait_result("add_ff_ff_c", 9'h1FF, 0);

    // Result held under 5 cycles of backpressure
    issue(8'hA5, 8'h3C, 1'b1);
    wait_result("bp5", ref_add(8'hA5, 8'h3C, 1'b1), 5);

    // New operand set offered during SHIFT is ignored until IDLE
    issue(8'h12, 8'h34, 1'b0);
    bus.in_valid = 1'b1;
    bus.a        = 8'h80;
    bus.b        = 8'h81;
    bus.cin      = 1'b1;
    wait_result("ovl_first", 9'h046, 0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("ovl_second_accepted", 32'(bus.busy), 32'd1);
    wait_result("ovl_second", 9'h102, 0);

    // Reset during the third SHIFT cycle aborts the operation
    issue(8'h55, 8'h66, 1'b1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_rst_in_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    check("abort_out_valid", 32'(bus.out_valid), 32'd0);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_result", 32'({bus.cout, bus.sum}), 32'd0);
    #1;
    check("abort_in_ready", 32'(bus.in_ready), 32'd1);
    seen_valid = 1'b0;
    for (int n = 0; n < WIDTH + 4; n++) begin
      @(negedge clk);
      if (bus.out_valid) seen_valid = 1'b1;
    end
    check("abort_no_valid", 32'(seen_valid), 32'd0);
    issue(8'h10, 8'h20, 1'b0);
    wait_result("after_abort", 9'h030, 0);

    // Randomized operations with random backpressure and idle gaps
    for (int i = 0; i < 1000; i++) begin
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      rc = 1'($urandom);
      issue(ra, rb, rc);
      wait_result("rand", ref_add(ra, rb, rc), int'($urandom_range(0, 3)));
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_serial_adder
`default_nettype wire
